// File: rtl/dma_desc_sched.sv
// Multi-channel DMA descriptor scheduler with per-channel show-ahead FIFOs,
// round-robin issue to one engine, completion counters and sticky errors.
//
// Ports:
//   clk, reset        sole clock, synchronous active-high reset
//   enq_en/enq_data   per-channel descriptor write (channel i at i*DESC_W)
//   enq_not_full      per-channel FIFO can accept a write
//   chan_stop         per-channel exclusion from arbitration
//   err_clear         per-channel pulse clearing the sticky error
//   desc_valid/ready  descriptor handshake toward the engine
//   desc_data/chan    issued descriptor and its channel
//   done/done_err     engine completion pulse and its error qualifier
//   chan_pending      per-channel FIFO occupancy
//   chan_done_cnt     per-channel completed-descriptor count
//   chan_err          per-channel sticky error
//   busy              a descriptor is issued or outstanding
`timescale 1ns/1ps

module dma_desc_sched #(
  parameter int NUM_CHAN   = 4,
  parameter int DESC_W     = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16,
  parameter int CHAN_W     =
    (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CHAN-1:0]  enq_en,
  input  logic [NUM_CHAN*DESC_W-1:0]
                               enq_data,
  output logic [NUM_CHAN-1:0]  enq_not_full,
  input  logic [NUM_CHAN-1:0]  chan_stop,
  input  logic [NUM_CHAN-1:0]  err_clear,
  output logic                 desc_valid,
  input  logic                 desc_ready,
  output logic [DESC_W-1:0]    desc_data,
  output logic [CHAN_W-1:0]    desc_chan,
  input  logic                 done,
  input  logic                 done_err,
  output logic [NUM_CHAN*($clog2(FIFO_DEPTH)+1)-1:0]
                               chan_pending,
  output logic [NUM_CHAN*CNT_W-1:0]
                               chan_done_cnt,
  output logic [NUM_CHAN-1:0]  chan_err,
  output logic                 busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;

  logic [NUM_CHAN-1:0][OCC_W-1:0]  occ;
  logic [NUM_CHAN-1:0][DESC_W-1:0] head;
  logic [NUM_CHAN-1:0][CNT_W-1:0]  done_cnt;
  logic [NUM_CHAN-1:0]             err_q;
  logic [NUM_CHAN-1:0]             elig;
  logic [NUM_CHAN-1:0]             deq;
  logic [CHAN_W-1:0]               rr_ptr;
  logic [CHAN_W-1:0]               grant_idx;
  logic                            grant_vld;

  // Per-channel show-ahead FIFOs
  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_ch
    logic [DESC_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;

    assign enq_not_full[i] =
      (occ[i] != OCC_W'(FIFO_DEPTH));
    assign push = enq_en[i] & enq_not_full[i];
    assign head[i] = mem[rd_ptr];
    assign elig[i] = (occ[i] != '0)
                   & ~chan_stop[i]
                   & ~err_q[i];

    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr] <=
          enq_data[i*DESC_W +: DESC_W];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ[i] <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (deq[i]) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        unique case ({push, deq[i]})
          2'b10:   occ[i] <= occ[i] + 1'b1;
          2'b01:   occ[i] <= occ[i] - 1'b1;
          default: occ[i] <= occ[i];
        endcase
      end
    end
  end

  // First eligible channel at or after rr_ptr, wrapping
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_CHAN; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CHAN) begin
        idx = idx - NUM_CHAN;
      end
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant_idx = CHAN_W'(idx);
      end
    end
  end

  // The granted entry leaves its FIFO in the cycle it is registered
  always_comb begin
    deq = '0;
    if (state == IDLE && grant_vld) begin
      deq[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      desc_valid <= 1'b0;
      desc_data  <= '0;
      desc_chan  <= '0;
      busy       <= 1'b0;
      rr_ptr     <= '0;
      done_cnt   <= '0;
      err_q      <= '0;
    end else begin
      err_q <= err_q & ~err_clear;
      unique case (state)
        IDLE: begin
          if (grant_vld) begin
            desc_data  <= head[grant_idx];
            desc_chan  <= grant_idx;
            desc_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (desc_ready) begin
            desc_valid <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (done) begin
            done_cnt[desc_chan] <=
              done_cnt[desc_chan] + 1'b1;
            // Placed after the clear so a
            // coincident error set wins
            if (done_err) begin
              err_q[desc_chan] <= 1'b1;
            end
            if (desc_chan ==
                CHAN_W'(NUM_CHAN - 1)) begin
              rr_ptr <= '0;
            end else begin
              rr_ptr <= desc_chan + 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          desc_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign chan_pending  = occ;
  assign chan_done_cnt = done_cnt;
  assign chan_err      = err_q;

endmodule

// File: tb/tb_dma_desc_sched.sv
// Directed self-checking bench for dma_desc_sched
// (NUM_CHAN=4, DESC_W=256, FIFO_DEPTH=16, CNT_W=16).
`timescale 1ns/1ps

module tb_dma_desc_sched;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    enq_en;
  logic [1023:0] enq_data;
  logic [3:0]    enq_not_full;
  logic [3:0]    chan_stop;
  logic [3:0]    err_clear;
  logic          desc_valid;
  logic          desc_ready;
  logic [255:0]  desc_data;
  logic [1:0]    desc_chan;
  logic          done;
  logic          done_err;
  logic [19:0]   chan_pending;
  logic [63:0]   chan_done_cnt;
  logic [3:0]    chan_err;
  logic          busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dma_desc_sched dut (
    .clk           (clk),
    .reset         (reset),
    .enq_en        (enq_en),
    .enq_data      (enq_data),
    .enq_not_full  (enq_not_full),
    .chan_stop     (chan_stop),
    .err_clear     (err_clear),
    .desc_valid    (desc_valid),
    .desc_ready    (desc_ready),
    .desc_data     (desc_data),
    .desc_chan     (desc_chan),
    .done          (done),
    .done_err      (done_err),
    .chan_pending  (chan_pending),
    .chan_done_cnt (chan_done_cnt),
    .chan_err      (chan_err),
    .busy          (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag,
                       logic [255:0] obs,
                       logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] pend(int ch);
    return chan_pending[ch*5 +: 5];
  endfunction

  task automatic enq(int ch, logic [255:0] d);
    enq_data = '0;
    enq_data[ch*256 +: 256] = d;
    enq_en = 4'b0001 << ch;
    tick();
    enq_en = '0;
    enq_data = '0;
  endtask

  task automatic wait_valid(string tag);
    int n = 0;
    while (!desc_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 256'(desc_valid), 1);
  endtask

  task automatic serve(string tag, int ch,
                       logic [255:0] d,
                       bit err, logic [3:0] clr);
    wait_valid(tag);
    check({tag, "_chan"}, 256'(desc_chan), 256'(ch));
    check({tag, "_data"}, desc_data, d);
    desc_ready = 1'b1;
    tick();
    desc_ready = 1'b0;
    check({tag, "_wait"},
          256'({busy, desc_valid}), 256'(2'b10));
    repeat (3) tick();
    done = 1'b1;
    done_err = err;
    err_clear = clr;
    tick();
    done = 1'b0;
    done_err = 1'b0;
    err_clear = '0;
    check({tag, "_idle"}, 256'(busy), 0);
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_vb"},
          256'({desc_valid, busy}), 0);
    check({tag, "_data"}, desc_data, 0);
    check({tag, "_chan"}, 256'(desc_chan), 0);
    check({tag, "_pend"}, 256'(chan_pending), 0);
    check({tag, "_nf"}, 256'(enq_not_full), 256'hF);
    check({tag, "_cnt"}, 256'(chan_done_cnt), 0);
    check({tag, "_err"}, 256'(chan_err), 0);
  endtask

  initial begin
    reset = 1'b1;
    enq_en = '0;
    enq_data = '0;
    chan_stop = '0;
    err_clear = '0;
    desc_ready = 1'b0;
    done = 1'b0;
    done_err = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_vals("rst");

    // Single channel, in-order issue
    chan_stop = 4'hF;
    for (int k = 0; k < 3; k++) enq(0, 256'h100 + k);
    check("t1_pend3", 256'(pend(0)), 3);
    check("t1_noissue", 256'(desc_valid), 0);
    chan_stop = 4'h0;
    tick();
    check("t1_latency", 256'(desc_valid), 1);
    for (int k = 0; k < 3; k++)
      serve("t1", 0, 256'h100 + k, 1'b0, 4'h0);
    check("t1_cnt0", 256'(chan_done_cnt[15:0]), 3);
    check("t1_pend0", 256'(pend(0)), 0);
    check("t1_busy", 256'(busy), 0);

    // Fairness from rr_ptr=0, ch2 empty
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chan_stop = 4'hF;
    for (int s = 0; s < 2; s++) begin
      enq(0, 256'h1000 + s);
      enq(1, 256'h1010 + s);
      enq(3, 256'h1030 + s);
    end
    chan_stop = 4'h0;
    for (int s = 0; s < 2; s++) begin
      serve("t2_c0", 0, 256'h1000 + s, 1'b0, 4'h0);
      serve("t2_c1", 1, 256'h1010 + s, 1'b0, 4'h0);
      serve("t2_c3", 3, 256'h1030 + s, 1'b0, 4'h0);
    end
    check("t2_cnts", 256'(chan_done_cnt),
          256'({16'd2, 16'd0, 16'd2, 16'd2}));

    // Backpressure, plus stop during ISSUE
    enq(1, 256'hBEEF);
    tick();
    check("t3_valid", 256'(desc_valid), 1);
    chan_stop = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t3_hold",
            {desc_valid, desc_chan, desc_data[252:0]},
            {1'b1, 2'd1, 253'hBEEF});
    end
    desc_ready = 1'b1;
    tick();
    desc_ready = 1'b0;
    chan_stop = 4'h0;
    check("t3_wait", 256'({busy, desc_valid}), 256'(2'b10));
    repeat (2) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t3_cnt1", 256'(chan_done_cnt[31:16]), 3);

    // done outside WAIT is ignored
    done = 1'b1;
    done_err = 1'b1;
    tick();
    done = 1'b0;
    done_err = 1'b0;
    check("t3_stray_cnt", 256'(chan_done_cnt),
          256'({16'd2, 16'd0, 16'd3, 16'd2}));
    check("t3_stray_err", 256'(chan_err), 0);

    // Error handling (rr_ptr=2 now)
    chan_stop = 4'hF;
    for (int k = 0; k < 3; k++) enq(1, 256'hE0 + k);
    enq(2, 256'hF0);
    chan_stop = 4'h0;
    serve("t4_f0", 2, 256'hF0, 1'b0, 4'h0);
    serve("t4_e0", 1, 256'hE0, 1'b1, 4'h0);
    check("t4_err_set", 256'(chan_err), 256'(4'b0010));
    repeat (3) tick();
    check("t4_skip", 256'(desc_valid), 0);
    check("t4_pend1", 256'(pend(1)), 2);
    enq(0, 256'h60);
    serve("t4_g0", 0, 256'h60, 1'b0, 4'h0);
    err_clear = 4'b0010;
    tick();
    err_clear = 4'h0;
    check("t4_err_clr", 256'(chan_err), 0);
    serve("t4_e1", 1, 256'hE1, 1'b1, 4'b0010);
    check("t4_set_wins", 256'(chan_err), 256'(4'b0010));
    repeat (2) tick();
    check("t4_skip2", 256'(desc_valid), 0);
    err_clear = 4'b0010;
    tick();
    err_clear = 4'h0;
    serve("t4_e2", 1, 256'hE2, 1'b0, 4'h0);
    check("t4_err_end", 256'(chan_err), 0);
    check("t4_pend1_end", 256'(pend(1)), 0);

    // Full FIFO while stopped
    chan_stop = 4'b0100;
    for (int k = 0; k < 17; k++) enq(2, 256'h2000 + k);
    check("t5_pend16", 256'(pend(2)), 16);
    check("t5_nf", 256'(enq_not_full), 256'(4'b1011));
    check("t5_noissue", 256'(desc_valid), 0);
    chan_stop = 4'h0;
    for (int k = 0; k < 16; k++)
      serve("t5", 2, 256'h2000 + k, 1'b0, 4'h0);
    check("t5_pend0", 256'(pend(2)), 0);
    check("t5_nf_end", 256'(enq_not_full), 256'hF);
    check("t5_cnts", 256'(chan_done_cnt),
          256'({16'd2, 16'd17, 16'd6, 16'd3}));

    // Reset while WAIT with 4 entries pending
    chan_stop = 4'h1;
    for (int k = 0; k < 5; k++) enq(0, 256'h3000 + k);
    chan_stop = 4'h0;
    wait_valid("t6");
    check("t6_data", desc_data, 256'h3000);
    desc_ready = 1'b1;
    tick();
    desc_ready = 1'b0;
    check("t6_pend4", 256'(pend(0)), 4);
    check("t6_busy", 256'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("t6_rst");
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t6_late_done", 256'(chan_done_cnt), 0);
    repeat (2) tick();
    check("t6_empty", 256'({desc_valid, busy}), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_desc_sched.md
Name: dma_desc_sched

Overview:
- Multi-channel descriptor scheduler; next generation of the single-FIFO descriptor path in the DMA top level.
- Buffers descriptors for NUM_CHAN independent host-visible channels, each with its own FIFO.
- Arbitrates round-robin among eligible channels and issues one descriptor at a time to the shared dma_engine over a valid/ready handshake.
- Tracks completion, sticky errors and per-channel counts for CSR status readback.

Parameters:
- NUM_CHAN, 4, number of descriptor channels (1..16).
- DESC_W, 256, descriptor width in bits.
- FIFO_DEPTH, 16, entries per channel FIFO; power of 2, at least 2.
- CNT_W, 16, width of the per-channel completion counter.
- CHAN_W, $clog2(NUM_CHAN) with minimum 1, channel index width (derived).

Ports:
- clk, in, 1, sole clock.
- reset, in, 1, synchronous, active-high.
- enq_en, in, NUM_CHAN, per-channel descriptor write strobe.
- enq_data, in, NUM_CHAN*DESC_W, per-channel descriptor data; channel i occupies bits [i*DESC_W +: DESC_W].
- enq_not_full, out, NUM_CHAN, channel FIFO can accept a write.
- chan_stop, in, NUM_CHAN, CSR stop; channel is excluded from arbitration.
- err_clear, in, NUM_CHAN, one-cycle pulse that clears the channel's sticky error.
- desc_valid, out, 1, descriptor offered to the engine.
- desc_ready, in, 1, engine accepts the descriptor.
- desc_data, out, DESC_W, issued descriptor.
- desc_chan, out, CHAN_W, channel of the issued descriptor.
- done, in, 1, engine completion pulse for the outstanding descriptor.
- done_err, in, 1, qualifies done; 1 = descriptor ended in error.
- chan_pending, out, NUM_CHAN*($clog2(FIFO_DEPTH)+1), per-channel FIFO occupancy.
- chan_done_cnt, out, NUM_CHAN*CNT_W, per-channel completed-descriptor count.
- chan_err, out, NUM_CHAN, sticky per-channel error.
- busy, out, 1, a descriptor is issued or outstanding.

Behaviour:
- Reset values:
  - desc_valid=0, busy=0, desc_data=0, desc_chan=0.
  - All FIFOs empty: chan_pending=0, enq_not_full=all 1s.
  - chan_done_cnt=0, chan_err=0, round-robin pointer=0, FSM in IDLE.
- FIFOs:
  - Show-ahead. An enqueue is accepted only when enq_en[i] & enq_not_full[i]; writes to a full FIFO are dropped and occupancy is unchanged.
  - Occupancy reflects an accepted write on the next cycle.
  - Simultaneous enqueue and dequeue on the same channel leaves occupancy unchanged.
- Eligibility: elig[i] = FIFO nonempty & ~chan_stop[i] & ~chan_err[i].
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any elig bit is set, grant the first eligible channel at or after rr_ptr, wrapping modulo NUM_CHAN.
  - Register the head descriptor into desc_data and the channel into desc_chan, dequeue that entry in the same cycle, go to ISSUE.
  - Arbitration plus registration costs 1 cycle, so desc_valid rises the cycle after eligibility is seen.
- ISSUE:
  - desc_valid=1; desc_data and desc_chan stay stable until the handshake.
  - On desc_valid & desc_ready go to WAIT; desc_valid drops the next cycle.
  - chan_stop asserted during ISSUE does not withdraw the descriptor; it is already dequeued.
- WAIT:
  - On done: increment chan_done_cnt[desc_chan], wrapping modulo 2^CNT_W.
  - If done_err, also set chan_err[desc_chan].
  - Set rr_ptr = desc_chan+1, wrapping to 0 after NUM_CHAN-1. Go to IDLE.
- busy = (state != IDLE).
- Minimum back-to-back issue spacing: done to next desc_valid is 2 cycles (WAIT->IDLE->ISSUE).
- done outside WAIT is ignored: no counter change, no error.
- Same-cycle err_clear[i] and a done_err setting chan_err[i]: set wins.
- A stopped or errored channel keeps its FIFO contents and keeps accepting enqueues up to full.
- Reset mid-operation:
  - All state returns to reset values and FIFO contents are discarded.
  - An outstanding engine operation is the engine's responsibility; its late done is ignored because the FSM is in IDLE.
- NUM_CHAN=1 degenerates to a single FIFO with completion tracking; desc_chan is always 0.

Test Plan:
- Single channel: enqueue 3 descriptors on ch0, desc_ready tied 1, done 5 cycles after each accept -> 3 issues in order, chan_done_cnt[0]=3, chan_pending[0]=0, busy=0 at end.
- Fairness: ch0, ch1 and ch3 each hold 2 descriptors, ch2 empty, rr_ptr=0 -> issue order 0,1,3,0,1,3; ch2 never granted.
- Backpressure: desc_ready held 0 for 10 cycles during ISSUE -> desc_valid stays 1 and desc_data/desc_chan stay stable; accepted on the cycle ready rises, WAIT the next cycle.
- Error: done with done_err on ch1 -> chan_err[1]=1 and ch1 skipped while holding 2 entries; err_clear[1] pulse -> ch1 resumes; a coincident done_err on ch1 in the same cycle keeps chan_err[1]=1.
- Full/stop: 17 enqueues to ch2 with chan_stop[2]=1 and FIFO_DEPTH=16 -> chan_pending[2]=16, enq_not_full[2]=0, 17th write dropped, no issues; release stop -> 16 issues.
- Reset asserted in WAIT with 4 entries pending -> next cycle all outputs at reset values; a later done pulse leaves chan_done_cnt=0.
